// File: rtl/ksz_bus_pkg.sv
// Shared definitions for the KSZ8851 host-bus engine and the sequencers
// that pace against its published phase code.
package ksz_bus_pkg;

  // Phase codes published on the engine's state output
  localparam logic [3:0] ST_ADDR0  = 4'd0;
  localparam logic [3:0] ST_ADDR1  = 4'd1;
  localparam logic [3:0] ST_ADDR2  = 4'd2;
  localparam logic [3:0] ST_READ0  = 4'd3;
  localparam logic [3:0] ST_READ1  = 4'd4;
  localparam logic [3:0] ST_READ2  = 4'd5;
  localparam logic [3:0] ST_WRITE0 = 4'd6;
  localparam logic [3:0] ST_WRITE1 = 4'd7;
  localparam logic [3:0] ST_WRITE2 = 4'd8;
  localparam logic [3:0] ST_WAIT   = 4'd9;

  // Byte-enable patterns placed in the top nibble of the address word
  localparam logic [3:0] BE_WORD_LOW  = 4'b0011;
  localparam logic [3:0] BE_WORD_HIGH = 4'b1100;
  localparam logic [3:0] BE_BYTE0     = 4'b0001;

  // Default phase lengths in clk40m cycles (2 strobe cycles = 50 ns)
  localparam int STROBE_CYCLES_DEFAULT   = 2;
  localparam int RECOVERY_CYCLES_DEFAULT = 1;

  // Registered pin levels, all derived from the phase being entered
  typedef struct packed {
    logic csn;
    logic cmd;
    logic rdn;
    logic wrn;
    logic oe;
  } pins_t;

  localparam pins_t PINS_IDLE = '{csn: 1'b1, cmd: 1'b0, rdn: 1'b1, wrn: 1'b1, oe: 1'b0};

  function automatic logic [3:0] byteEnable(input logic [7:0] off, input logic len);
    if (len) begin
      return off[1] ? BE_WORD_HIGH : BE_WORD_LOW;
    end
    return BE_BYTE0 << off[1:0];
  endfunction

  function automatic logic [15:0] addressWord(input logic [7:0] off, input logic len);
    return {byteEnable(off, len), 4'h0, off[7:2], 2'b00};
  endfunction

  // Strobes are only low in the strobe phases, and the bus is only driven
  // in address/write phases, so overlap rules fall out of this table.
  function automatic pins_t pinsFor(input logic [3:0] st);
    pins_t p;
    p.csn = (st == ST_WAIT);
    p.cmd = (st == ST_ADDR0) || (st == ST_ADDR1) || (st == ST_ADDR2);
    p.rdn = (st != ST_READ1);
    p.wrn = !((st == ST_ADDR1) || (st == ST_WRITE1));
    p.oe  = p.cmd || (st == ST_WRITE0) || (st == ST_WRITE1) || (st == ST_WRITE2);
    return p;
  endfunction

endpackage

// File: rtl/ksz_phase_timer.sv
// Loadable down-counter that times each strobe and recovery phase.
// done_o is high while the count has reached zero.
module ksz_phase_timer (
  input  logic       clk40m,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] loadValue_i,
  output logic       done_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // Counter register, cleared by the active-low reset
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/ksz_bus_engine.sv
// Responder for the register-command interface: runs one KSZ8851 16-bit
// host-bus cycle (address phase, then data phase) per command and
// publishes its current phase so the sequencers can pace against it.
module ksz_bus_engine
  import ksz_bus_pkg::*;
#(
  parameter int STROBE_CYCLES   = STROBE_CYCLES_DEFAULT,
  parameter int RECOVERY_CYCLES = RECOVERY_CYCLES_DEFAULT
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        NewCommand,
  input  logic        WR,
  input  logic [7:0]  offset,
  input  logic        length,
  input  logic [15:0] writeData,
  output logic [15:0] readData,
  output logic [3:0]  state,
  output logic        eth_csn,
  output logic        eth_cmd,
  output logic        eth_rdn,
  output logic        eth_wrn,
  output logic [15:0] sd_o,
  output logic        sd_oe,
  input  logic [15:0] sd_i
);

  localparam logic [3:0] STROBE_LOAD   = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_CYCLES - 1);

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  pins_t       pins_q;
  pins_t       pins_d;
  logic        wrLatch_q;
  logic        lengthLatch_q;
  logic        byteLane_q;
  logic [15:0] sdOut_q;
  logic [15:0] sdOut_d;
  logic [15:0] readData_q;
  logic [15:0] readData_d;
  logic [15:0] liveAddress;
  logic        timerLoad;
  logic [3:0]  timerLoadValue;
  logic        phaseDone;

  assign liveAddress = addressWord(offset, length);

  // Phase sequencing: timed phases leave when the timer reports done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (NewCommand) state_d = ST_ADDR0;
      ST_ADDR0:  state_d = ST_ADDR1;
      ST_ADDR1:  if (phaseDone) state_d = ST_ADDR2;
      ST_ADDR2:  if (phaseDone) state_d = wrLatch_q ? ST_WRITE0 : ST_READ0;
      ST_READ0:  state_d = ST_READ1;
      ST_READ1:  if (phaseDone) state_d = ST_READ2;
      ST_READ2:  if (phaseDone) state_d = NewCommand ? ST_ADDR0 : ST_WAIT;
      ST_WRITE0: state_d = ST_WRITE1;
      ST_WRITE1: if (phaseDone) state_d = ST_WRITE2;
      ST_WRITE2: if (phaseDone) state_d = NewCommand ? ST_ADDR0 : ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
  end

  // Timer reload value for the phase about to be entered
  always_comb begin
    timerLoad      = (state_d != state_q);
    timerLoadValue = 4'd0;
    case (state_d)
      ST_ADDR1, ST_READ1, ST_WRITE1: timerLoadValue = STROBE_LOAD;
      ST_ADDR2, ST_READ2, ST_WRITE2: timerLoadValue = RECOVERY_LOAD;
      default:                       timerLoadValue = 4'd0;
    endcase
  end

  ksz_phase_timer u_phaseTimer (
    .clk40m      (clk40m),
    .reset       (reset),
    .load_i      (timerLoad),
    .loadValue_i (timerLoadValue),
    .done_o      (phaseDone)
  );

  // Bus drive value: address captured leaving Addr0, write data leaving Addr2
  always_comb begin
    sdOut_d = sdOut_q;
    if (state_q == ST_ADDR0) begin
      sdOut_d = liveAddress;
    end else if ((state_q == ST_ADDR2) && phaseDone && wrLatch_q) begin
      sdOut_d = lengthLatch_q ? writeData : {writeData[7:0], writeData[7:0]};
    end
  end

  // Read result is only captured on the final Read1 cycle
  always_comb begin
    readData_d = readData_q;
    if ((state_q == ST_READ1) && phaseDone) begin
      if (lengthLatch_q) begin
        readData_d = sd_i;
      end else begin
        readData_d = {8'h00, byteLane_q ? sd_i[15:8] : sd_i[7:0]};
      end
    end
  end

  assign pins_d = pinsFor(state_d);

  // Phase, pin and data registers; reset drops every strobe at once
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAIT;
      pins_q     <= PINS_IDLE;
      sdOut_q    <= 16'h0000;
      readData_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pins_q     <= pins_d;
      sdOut_q    <= sdOut_d;
      readData_q <= readData_d;
    end
  end

  // Command fields are frozen when Addr0 ends so the sequencer may move on
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      wrLatch_q     <= 1'b0;
      lengthLatch_q <= 1'b0;
      byteLane_q    <= 1'b0;
    end else if (state_q == ST_ADDR0) begin
      wrLatch_q     <= WR;
      lengthLatch_q <= length;
      byteLane_q    <= offset[0];
    end
  end

  assign state    = state_q;
  assign readData = readData_q;
  assign eth_csn  = pins_q.csn;
  assign eth_cmd  = pins_q.cmd;
  assign eth_rdn  = pins_q.rdn;
  assign eth_wrn  = pins_q.wrn;
  assign sd_oe    = pins_q.oe;
  assign sd_o     = (state_q == ST_ADDR0) ? liveAddress : sdOut_q;

endmodule

// File: tb/tb_ksz_bus_engine.sv
// Self-checking bench for ksz_bus_engine: a vector table of single
// commands, hand sequences for back-to-back and mid-cycle reset, and a
// bus monitor that compares observed transactions against a scoreboard.
module tb_ksz_bus_engine;

  typedef struct {
    logic        wr;
    logic [7:0]  offset;
    logic        length;
    logic [15:0] writeData;
    logic [15:0] chipData;
    logic [15:0] expAddr;
    logic [15:0] expData;
  } vector_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } expTxn_t;

  logic        clk40m;
  logic        reset;
  logic        NewCommand;
  logic        WR;
  logic [7:0]  offset;
  logic        length;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic [3:0]  state;
  logic        eth_csn;
  logic        eth_cmd;
  logic        eth_rdn;
  logic        eth_wrn;
  logic [15:0] sd_o;
  logic        sd_oe;
  logic [15:0] sd_i;
  logic [15:0] chipData;

  int checks = 0;
  int failures = 0;
  int invariantErrors = 0;
  expTxn_t sbQueue[$];
  vector_t vectors[8];

  ksz_bus_engine dut (
    .clk40m     (clk40m),
    .reset      (reset),
    .NewCommand (NewCommand),
    .WR         (WR),
    .offset     (offset),
    .length     (length),
    .writeData  (writeData),
    .readData   (readData),
    .state      (state),
    .eth_csn    (eth_csn),
    .eth_cmd    (eth_cmd),
    .eth_rdn    (eth_rdn),
    .eth_wrn    (eth_wrn),
    .sd_o       (sd_o),
    .sd_oe      (sd_oe),
    .sd_i       (sd_i)
  );

  // Chip model: drives the register value only while RDN is low
  assign sd_i = eth_rdn ? 16'hDEAD : chipData;

  initial clk40m = 1'b0;
  always #5 clk40m = ~clk40m;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic scoreboardCompare(input logic wr, input logic [15:0] addr, input logic [15:0] data);
    expTxn_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("unexpectedTxn", 1, 0);
    end else begin
      e = sbQueue.pop_front();
      checkOutput("txnKind", wr, e.wr);
      checkOutput("txnAddr", addr, e.addr);
      checkOutput("txnData", data, e.data);
    end
  endtask

  // Bus monitor: reconstructs transactions from the pins and checks strobe rules
  logic        prevCmd;
  logic        prevRdn;
  logic        prevWrn;
  logic [15:0] seenAddr;
  logic [15:0] writeHold;
  int          rdnLow;

  always @(negedge clk40m) begin
    if (!reset) begin
      prevCmd = 1'b0;
      prevRdn = 1'b1;
      prevWrn = 1'b1;
      rdnLow  = 0;
    end else begin
      if (!eth_rdn && !eth_wrn) invariantErrors++;
      if (sd_oe && !eth_rdn) invariantErrors++;
      if ((eth_cmd != prevCmd) && !(eth_rdn && eth_wrn && prevRdn && prevWrn)) invariantErrors++;
      if (eth_cmd && !eth_wrn && prevWrn) seenAddr = sd_o;
      if (!eth_cmd && !eth_wrn && prevWrn) begin
        writeHold = sd_o;
        scoreboardCompare(1'b1, seenAddr, sd_o);
      end
      if (!eth_cmd && !eth_wrn && !prevWrn && (sd_o != writeHold)) invariantErrors++;
      if (!eth_rdn) rdnLow++;
      if (!eth_cmd && eth_rdn && !prevRdn) begin
        scoreboardCompare(1'b0, seenAddr, readData);
        checkOutput("rdnWidth", rdnLow, 2);
        rdnLow = 0;
      end
      prevCmd = eth_cmd;
      prevRdn = eth_rdn;
      prevWrn = eth_wrn;
    end
  end

  // Issue one command from Wait and record the phase trace until Wait returns
  task automatic applyStimulus(input vector_t v, output logic [127:0] trace, output int n);
    expTxn_t e;
    bit scrambled;
    trace = '0;
    n = 0;
    scrambled = 1'b0;
    WR = v.wr;
    offset = v.offset;
    length = v.length;
    writeData = v.writeData;
    chipData = v.chipData;
    NewCommand = 1'b1;
    e.wr = v.wr;
    e.addr = v.expAddr;
    e.data = v.expData;
    sbQueue.push_back(e);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk40m);
      if (n < 32) trace[4*n +: 4] = state;
      n++;
      if (state == 4'd0) NewCommand = 1'b0;
      if ((state == 4'd1) && !scrambled) begin
        WR = ~v.wr;
        offset = ~v.offset;
        length = ~v.length;
        scrambled = 1'b1;
      end
      if (state == 4'd9) break;
    end
  endtask

  initial begin
    logic [127:0] trace;
    logic [127:0] expTrace;
    int n;
    int zeroCount;
    int csnHigh;
    logic [15:0] lastReadExp;
    vector_t v;

    vectors[0] = '{1'b0, 8'hC0, 1'b1, 16'h0000, 16'h8872, 16'h30C0, 16'h8872};
    vectors[1] = '{1'b1, 8'h10, 1'b1, 16'h89AB, 16'h0000, 16'h3010, 16'h89AB};
    vectors[2] = '{1'b0, 8'h93, 1'b0, 16'h0000, 16'hA55A, 16'h8090, 16'h00A5};
    vectors[3] = '{1'b1, 8'h21, 1'b0, 16'h1234, 16'h0000, 16'h2020, 16'h3434};
    vectors[4] = '{1'b0, 8'h02, 1'b0, 16'h0000, 16'hA55A, 16'h4000, 16'h005A};
    vectors[5] = '{1'b1, 8'h46, 1'b1, 16'hBEEF, 16'h0000, 16'hC044, 16'hBEEF};
    vectors[6] = '{1'b0, 8'h81, 1'b0, 16'h0000, 16'h1357, 16'h2080, 16'h0013};
    vectors[7] = '{1'b0, 8'h7E, 1'b1, 16'h0000, 16'hFFFF, 16'hC07C, 16'hFFFF};

    reset = 1'b0;
    NewCommand = 1'b0;
    WR = 1'b0;
    offset = 8'h00;
    length = 1'b0;
    writeData = 16'h0000;
    chipData = 16'h0000;
    lastReadExp = 16'h0000;

    repeat (3) begin
      @(negedge clk40m);
      checkOutput("resetState", {state, eth_csn, eth_cmd, eth_rdn, eth_wrn, sd_oe, sd_o, readData},
                  {4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000});
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk40m);
      checkOutput("idleAfterReset", {state, eth_csn, eth_rdn, eth_wrn, sd_oe}, {4'd9, 1'b1, 1'b1, 1'b1, 1'b0});
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i], trace, n);
      expTrace = vectors[i].wr ? 128'h987762110 : 128'h954432110;
      checkOutput("traceLen", n, 9);
      checkOutput("trace", trace, expTrace);
      if (!vectors[i].wr) lastReadExp = vectors[i].expData;
      checkOutput("readHold", readData, lastReadExp);
    end

    // Read-modify-write with NewCommand held: no Wait between the two commands
    WR = 1'b0;
    offset = 8'hF6;
    length = 1'b1;
    writeData = 16'hFFFF;
    chipData = 16'h0020;
    NewCommand = 1'b1;
    sbQueue.push_back('{1'b0, 16'hC0F4, 16'h0020});
    sbQueue.push_back('{1'b1, 16'hC0F4, 16'h2000});
    trace = '0;
    n = 0;
    zeroCount = 0;
    csnHigh = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk40m);
      if (n < 32) trace[4*n +: 4] = state;
      n++;
      if ((state != 4'd9) && eth_csn) csnHigh++;
      if (state == 4'd5) WR = 1'b1;
      if (state == 4'd0) begin
        zeroCount++;
        if (zeroCount == 2) begin
          writeData = 16'h2000;
          checkOutput("rmwReadInAddr0", readData, 16'h0020);
          NewCommand = 1'b0;
        end
      end
      if (state == 4'd9) break;
    end
    checkOutput("rmwTraceLen", n, 17);
    checkOutput("rmwTrace", trace, 128'h98776211054432110);
    checkOutput("rmwCsnHeld", csnHigh, 0);

    // Reset while WRN is low in Write1
    WR = 1'b1;
    offset = 8'h10;
    length = 1'b1;
    writeData = 16'h5A5A;
    NewCommand = 1'b1;
    sbQueue.push_back('{1'b1, 16'h3010, 16'h5A5A});
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk40m);
      if (state == 4'd0) NewCommand = 1'b0;
      if (state == 4'd7) break;
    end
    checkOutput("reachedWrite1", {state, eth_wrn}, {4'd7, 1'b0});
    #2 reset = 1'b0;
    #1 checkOutput("resetMidWrite", {state, eth_csn, eth_cmd, eth_rdn, eth_wrn, sd_oe, sd_o, readData},
                   {4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000});
    @(negedge clk40m);
    reset = 1'b1;
    repeat (2) @(negedge clk40m);
    checkOutput("postResetIdle", {state, eth_csn}, {4'd9, 1'b1});

    v = vectors[2];
    applyStimulus(v, trace, n);
    checkOutput("postResetTraceLen", n, 9);
    checkOutput("postResetTrace", trace, 128'h954432110);
    checkOutput("postResetRead", readData, 16'h00A5);

    repeat (3) @(negedge clk40m);
    checkOutput("strobeRules", invariantErrors, 0);
    checkOutput("scoreboardDrained", sbQueue.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
